sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Frame-buffer writer for the VGA output path. Accepts sprite draw commands from the game logic, walks each sprite rectangle pixel by pixel, and fetches palette indices from an external synchronous sprite ROM. Emits one framebuffer write per cycle on the `write_x` / `write_y` / `write_palette` bus of the VGA block. Runs entirely in `clk_33m`; uses `rst_screen_33m` to start each frame and to abort any unfinished work.

## Interface

Parameters:
- `COOR_WIDTH`, 12: width of framebuffer coordinates.
- `FRAME_W`, 1280: drawable width; pixels with x ≥ `FRAME_W` are clipped.
- `FRAME_H`, 300: drawable height; pixels with y ≥ `FRAME_H` are clipped.
- `SIZE_WIDTH`, 8: width of sprite width/height fields.
- `ROM_ADDR_WIDTH`, 16: sprite ROM address width.

Ports:
- `clk_33m`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rst_screen_33m`, in, 1: frame-swap window from the VGA block; high for several cycles per frame.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: command accepted when valid && ready.
- `cmd_x`, in, `COOR_WIDTH`: sprite top-left x.
- `cmd_y`, in, `COOR_WIDTH`: sprite top-left y.
- `cmd_w`, in, `SIZE_WIDTH`: sprite width in pixels.
- `cmd_h`, in, `SIZE_WIDTH`: sprite height in pixels.
- `cmd_base`, in, `ROM_ADDR_WIDTH`: ROM address of pixel (0,0); row-major layout with stride `cmd_w`.
- `rom_addr`, out, `ROM_ADDR_WIDTH`: registered ROM address.
- `rom_data`, in, 3: ROM palette index, valid 1 cycle after `rom_addr`.
- `write_x`, out, `COOR_WIDTH`: framebuffer write x.
- `write_y`, out, `COOR_WIDTH`: framebuffer write y.
- `write_palette`, out, 3: palette index; 0 means no write (transparent).
- `frame_start`, out, 1: one-cycle pulse on the rising edge of `rst_screen_33m`.
- `busy`, out, 1: FSM not IDLE, or pipeline holds a valid pixel.

## Operation

- **States:** IDLE and DRAW.
- **IDLE**
  - `cmd_ready` = !`rst_screen_33m`.
  - On accept, latch x, y, w, h, base.
  - If w == 0 or h == 0, stay in IDLE and emit no pixels.
  - Otherwise go to DRAW with i = 0, j = 0.
- **DRAW**
  - One pixel per cycle, row-major: i increments; when i == w-1, i ← 0 and j increments.
  - After the pixel with i == w-1 and j == h-1, go to IDLE.
  - `cmd_ready` is 0 throughout DRAW.
- **ROM addressing**
  - Address is incremental: base, base+1, …; no multiplier.
  - Address wraps modulo 2^`ROM_ADDR_WIDTH`.
- **Coordinates**
  - px = x + i and py = y + j, computed in `COOR_WIDTH` + 1 bits.
  - If px ≥ `FRAME_W` or py ≥ `FRAME_H`, the pixel is clipped: it still consumes its cycle, and `write_palette` is forced to 0.
  - A ROM value of 0 passes through as 0 (transparent).
- **Frame handling**
  - A rising edge of `rst_screen_33m` pulses `frame_start`.
  - If the FSM is in DRAW, the current command is aborted: FSM → IDLE and all pipeline valid bits are cleared.
  - While `rst_screen_33m` is high, `write_palette` is held at 0 and no command is accepted.
- **Reset values:** `cmd_ready` 0 (in reset only), `rom_addr` 0, `write_x` 0, `write_y` 0, `write_palette` 0, `frame_start` 0, `busy` 0, state IDLE.

## Timing

- **Pipeline stages:**
  - Cycle n: `rom_addr` and the pixel coordinates are registered.
  - Cycle n+1: `rom_data` arrives.
  - Cycle n+2: `write_x`, `write_y`, `write_palette` are registered outputs.
- **Accept to first write:** command accepted at edge k → first `rom_addr` at k+1 → first write visible at k+3.
- **Throughput:** a w×h sprite occupies DRAW for exactly w·h cycles.
- **Next command:** `cmd_ready` rises in the cycle after the last pixel leaves DRAW.
- **`busy`:** stays high until the last write has been presented.
- **`frame_start`:** asserted in the cycle after the synchronizer stage sees 0 → 1; `rst_screen_33m` is already in `clk_33m`.
- **Abort:** takes effect on the same edge as `frame_start`. No write with a nonzero `write_palette` appears from that edge on.
- **Simultaneous events:** `cmd_valid` together with a rising `rst_screen_33m` is not accepted.

## Structure

- **Package `vga_pkg`:**
  - `COOR_WIDTH`, `FRAME_W`, `FRAME_H`.
  - `palette_t` (logic [2:0]).
  - `PALETTE_TRANSPARENT` = 0.
  - `blit_cmd_t` struct: x, y, w, h, base.
- **Sub-module `blit_walker`:** i/j counters, incremental ROM address, last-pixel flag.
- **Top level:** FSM, frame edge detect, clip logic, 2-stage output pipeline.

## Test plan

- Cmd (x=10, y=20, w=2, h=2, base=0x100), ROM = 1,2,3,4 → `rom_addr` 0x100..0x103. Writes (10,20,1), (11,20,2), (10,21,3), (11,21,4) on consecutive cycles starting 3 cycles after accept; `busy` falls after the last write.
- Cmd (x=1278, y=299, w=4, h=2), all ROM = 5 → only (1278,299) and (1279,299) carry palette 5. The other 6 slots carry palette 0; 8 cycles of DRAW total.
- Cmd w=0 or h=0 → no ROM access, no writes, `cmd_ready` high again the next cycle.
- `rst_screen_33m` rises mid-sprite (8×8, after 20 pixels) → `frame_start` pulses once, `write_palette` is 0 from that edge on, FSM is IDLE, and `cmd_ready` stays 0 until `rst_screen_33m` falls.
- ROM pattern with zeros (0,7,0,7) → writes with palette 0 at transparent pixels, and coordinates still advance.
- `rst` asserted during DRAW → all outputs 0 immediately (asynchronous). After release, a fresh command draws correctly from base.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared types and constants for the VGA sprite blitter path.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int COOR_WIDTH     = 12;
  localparam int FRAME_W        = 1280;
  localparam int FRAME_H        = 300;
  localparam int SIZE_WIDTH     = 8;
  localparam int ROM_ADDR_WIDTH = 16;

  typedef logic [2:0] palette_t;

  // Palette index 0 is never written to the framebuffer.
  localparam palette_t PALETTE_TRANSPARENT = 3'd0;

  typedef struct packed {
    logic [COOR_WIDTH-1:0]     x;
    logic [COOR_WIDTH-1:0]     y;
    logic [SIZE_WIDTH-1:0]     w;
    logic [SIZE_WIDTH-1:0]     h;
    logic [ROM_ADDR_WIDTH-1:0] base;
  } blit_cmd_t;

endpackage
`default_nettype wire

// File: rtl/sprite_blitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_blitter_if
//  Purpose  : Sprite draw command channel (valid/ready plus rectangle fields).
//  Revision : 1.0 - initial release
// ============================================================================
import vga_pkg::*;

interface sprite_blitter_if #(
  parameter int COOR_WIDTH     = vga_pkg::COOR_WIDTH,
  parameter int SIZE_WIDTH     = vga_pkg::SIZE_WIDTH,
  parameter int ROM_ADDR_WIDTH = vga_pkg::ROM_ADDR_WIDTH
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [COOR_WIDTH-1:0]     cmd_x;
  logic [COOR_WIDTH-1:0]     cmd_y;
  logic [SIZE_WIDTH-1:0]     cmd_w;
  logic [SIZE_WIDTH-1:0]     cmd_h;
  logic [ROM_ADDR_WIDTH-1:0] cmd_base;

  // Game logic side: offers commands.
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base,
    input  cmd_ready
  );

  // Blitter side: accepts commands.
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/sprite_blitter_walker.sv
`default_nettype none
// ============================================================================
//  Module   : blit_walker
//  Purpose  : Row-major pixel walker: column/row counters, incremental ROM
//             address (base + running offset) and last-pixel flag.
//  Revision : 1.0 - initial release
// ============================================================================
import vga_pkg::*;

module blit_walker #(
  parameter int SIZE_WIDTH     = vga_pkg::SIZE_WIDTH,
  parameter int ROM_ADDR_WIDTH = vga_pkg::ROM_ADDR_WIDTH
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      load,
  input  wire logic                      step,
  input  wire logic [SIZE_WIDTH-1:0]     w,
  input  wire logic [SIZE_WIDTH-1:0]     h,
  input  wire logic [ROM_ADDR_WIDTH-1:0] base,
  output logic      [SIZE_WIDTH-1:0]     i,
  output logic      [SIZE_WIDTH-1:0]     j,
  output logic      [ROM_ADDR_WIDTH-1:0] addr,
  output logic                           last
);
  logic [ROM_ADDR_WIDTH-1:0] offset;
  logic                      row_end;

  // The offset simply counts pixels, so the ROM address wraps naturally.
  assign addr    = base + offset;
  assign row_end = (i == w - SIZE_WIDTH'(1));
  assign last    = row_end && (j == h - SIZE_WIDTH'(1));

  // Counters restart on a new command and advance once per drawn pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i      <= '0;
      j      <= '0;
      offset <= '0;
    end else if (load) begin
      i      <= '0;
      j      <= '0;
      offset <= '0;
    end else if (step) begin
      offset <= offset + ROM_ADDR_WIDTH'(1);
      if (row_end) begin
        i <= '0;
        j <= j + SIZE_WIDTH'(1);
      end else begin
        i <= i + SIZE_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_blitter
//  Purpose  : Walks sprite rectangles, fetches palette indices from a
//             synchronous sprite ROM and emits one framebuffer write per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
import vga_pkg::*;

module sprite_blitter #(
  parameter int COOR_WIDTH     = vga_pkg::COOR_WIDTH,
  parameter int FRAME_W        = vga_pkg::FRAME_W,
  parameter int FRAME_H        = vga_pkg::FRAME_H,
  parameter int SIZE_WIDTH     = vga_pkg::SIZE_WIDTH,
  parameter int ROM_ADDR_WIDTH = vga_pkg::ROM_ADDR_WIDTH
) (
  input  wire logic                      clk_33m,
  input  wire logic                      rst,
  input  wire logic                      rst_screen_33m,
  sprite_blitter_if.slave                cmd,
  output logic      [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  wire palette_t                  rom_data,
  output logic      [COOR_WIDTH-1:0]     write_x,
  output logic      [COOR_WIDTH-1:0]     write_y,
  output palette_t                       write_palette,
  output logic                           frame_start,
  output logic                           busy
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DRAW = 1'b1;

  logic [0:0]                state;
  blit_cmd_t                 cur;
  logic                      screen_q;
  logic                      screen_rise;
  logic                      accept;
  logic                      in_draw;
  logic [SIZE_WIDTH-1:0]     col;
  logic [SIZE_WIDTH-1:0]     row;
  logic [ROM_ADDR_WIDTH-1:0] walk_addr;
  logic                      walk_last;
  logic [COOR_WIDTH:0]       px;
  logic [COOR_WIDTH:0]       py;
  logic                      clip;

  // Pipeline: stage 1 holds the ROM request, stage 2 waits for ROM data.
  logic                      v1, v2, v3;
  logic                      clip1, clip2;
  logic [COOR_WIDTH-1:0]     x1, y1, x2, y2;

  assign screen_rise   = rst_screen_33m && !screen_q;
  assign in_draw       = (state == ST_DRAW);
  assign cmd.cmd_ready = (state == ST_IDLE) && !rst_screen_33m && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = in_draw || v1 || v2 || v3;

  // One extra bit so coordinates past the edge never wrap back on screen.
  assign px   = {1'b0, cur.x} + {{(COOR_WIDTH + 1 - SIZE_WIDTH){1'b0}}, col};
  assign py   = {1'b0, cur.y} + {{(COOR_WIDTH + 1 - SIZE_WIDTH){1'b0}}, row};
  assign clip = (px >= (COOR_WIDTH + 1)'(FRAME_W)) || (py >= (COOR_WIDTH + 1)'(FRAME_H));

  blit_walker #(
    .SIZE_WIDTH     (SIZE_WIDTH),
    .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH)
  ) u_walker (
    .clk  (clk_33m),
    .rst  (rst),
    .load (accept),
    .step (in_draw),
    .w    (cur.w),
    .h    (cur.h),
    .base (cur.base),
    .i    (col),
    .j    (row),
    .addr (walk_addr),
    .last (walk_last)
  );

  // Command FSM: a frame swap aborts drawing; empty sprites never enter DRAW.
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else if (screen_rise) begin
      state <= ST_IDLE;
    end else if (accept) begin
      cur <= '{x: cmd.cmd_x, y: cmd.cmd_y, w: cmd.cmd_w, h: cmd.cmd_h, base: cmd.cmd_base};
      if ((cmd.cmd_w != '0) && (cmd.cmd_h != '0)) begin
        state <= ST_DRAW;
      end
    end else if (in_draw && walk_last) begin
      state <= ST_IDLE;
    end
  end

  // Frame edge detect and the address / ROM-wait / write pipeline.
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      screen_q      <= 1'b0;
      frame_start   <= 1'b0;
      rom_addr      <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      clip1         <= 1'b0;
      clip2         <= 1'b0;
      x1            <= '0;
      y1            <= '0;
      x2            <= '0;
      y2            <= '0;
      write_x       <= '0;
      write_y       <= '0;
      write_palette <= PALETTE_TRANSPARENT;
    end else begin
      screen_q    <= rst_screen_33m;
      frame_start <= screen_rise;
      v1          <= in_draw && !screen_rise;
      if (in_draw) begin
        rom_addr <= walk_addr;
        x1       <= px[COOR_WIDTH-1:0];
        y1       <= py[COOR_WIDTH-1:0];
        clip1    <= clip;
      end
      v2      <= v1 && !screen_rise;
      x2      <= x1;
      y2      <= y1;
      clip2   <= clip1;
      v3      <= v2 && !screen_rise;
      write_x <= x2;
      write_y <= y2;
      // Clipped pixels and anything during the frame swap write nothing.
      write_palette <= (v2 && !clip2 && !rst_screen_33m) ? rom_data : PALETTE_TRANSPARENT;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_blitter
//  Purpose  : Directed scoreboard bench for sprite_blitter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;
  import vga_pkg::*;

  typedef struct {
    int         cyc;
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  pal;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [15:0] a;
  } ad_t;

  logic        clk_33m = 1'b0;
  logic        rst = 1'b1;
  logic        rst_screen_33m = 1'b0;
  logic [15:0] rom_addr;
  logic [2:0]  rom_data = 3'd0;
  logic [11:0] write_x;
  logic [11:0] write_y;
  logic [2:0]  write_palette;
  logic        frame_start;
  logic        busy;

  logic [2:0]  rom_mem [0:65535];
  wr_t         exp_q[$];
  ad_t         addr_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          k;

  always #5 clk_33m = ~clk_33m;

  sprite_blitter_if cmd_bus ();

  sprite_blitter dut (
    .clk_33m        (clk_33m),
    .rst            (rst),
    .rst_screen_33m (rst_screen_33m),
    .cmd            (cmd_bus),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .write_x        (write_x),
    .write_y        (write_y),
    .write_palette  (write_palette),
    .frame_start    (frame_start),
    .busy           (busy)
  );

  // Synchronous sprite ROM model.
  always @(posedge clk_33m) rom_data <= rom_mem[rom_addr];

  always @(posedge clk_33m) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: expected writes/addresses pop on their due cycle;
  // every other cycle must carry a transparent palette.
  always @(negedge clk_33m) begin : mon
    wr_t e;
    ad_t a;
    if (!rst) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("write_x", 32'(write_x), 32'(e.x));
        chk("write_y", 32'(write_y), 32'(e.y));
        chk("write_palette", 32'(write_palette), 32'(e.pal));
      end else begin
        chk("idle_palette", 32'(write_palette), 32'd0);
      end
      if (addr_q.size() != 0 && addr_q[0].cyc == cyc) begin
        a = addr_q.pop_front();
        chk("rom_addr", 32'(rom_addr), 32'(a.a));
      end
    end
  end

  task automatic at_neg(input int t);
    @(negedge clk_33m);
    while (cyc < t) @(negedge clk_33m);
    if (cyc != t) chk("schedule", 32'(cyc), 32'(t));
  endtask

  // Offer a command, then queue the expected ROM addresses and writes of the
  // first 'limit' pixels (later ones are expected to be suppressed).
  task automatic send_cmd(input int x, input int y, input int w, input int h,
                          input int base, input int limit, output int ka);
    int i, j, px, py;
    logic [15:0] adr;
    logic [2:0]  pal;
    @(negedge clk_33m);
    chk("cmd_ready_pre", 32'(cmd_bus.cmd_ready), 32'd1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_x     = 12'(x);
    cmd_bus.cmd_y     = 12'(y);
    cmd_bus.cmd_w     = 8'(w);
    cmd_bus.cmd_h     = 8'(h);
    cmd_bus.cmd_base  = 16'(base);
    @(posedge clk_33m);
    #1;
    ka = cyc;
    cmd_bus.cmd_valid = 1'b0;
    for (int n = 0; n < w * h && n < limit; n++) begin
      i   = n % w;
      j   = n / w;
      px  = x + i;
      py  = y + j;
      adr = 16'(base + n);
      pal = (px >= 1280 || py >= 300) ? 3'd0 : rom_mem[adr];
      addr_q.push_back('{cyc: ka + 1 + n, a: adr});
      exp_q.push_back('{cyc: ka + 3 + n, x: 12'(px), y: 12'(py), pal: pal});
    end
  endtask

  // Handshake and busy timing around the end of an n-pixel sprite.
  task automatic done(input int ka, input int n);
    if (n > 0) begin
      at_neg(ka + n - 1);
      chk("ready_in_draw", 32'(cmd_bus.cmd_ready), 32'd0);
    end
    at_neg(ka + n);
    chk("ready_after", 32'(cmd_bus.cmd_ready), 32'd1);
    if (n > 0) begin
      at_neg(ka + n + 2);
      chk("busy_last_write", 32'(busy), 32'd1);
    end
    at_neg(ka + n + 3);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, 32'(cmd_bus.cmd_ready), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_write_x"}, 32'(write_x), 32'd0);
    chk({tag, "_write_y"}, 32'(write_y), 32'd0);
    chk({tag, "_palette"}, 32'(write_palette), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_x     = '0;
    cmd_bus.cmd_y     = '0;
    cmd_bus.cmd_w     = '0;
    cmd_bus.cmd_h     = '0;
    cmd_bus.cmd_base  = '0;
    for (int a = 0; a < 65536; a++) rom_mem[a] = 3'd0;

    // Reset state.
    repeat (3) @(negedge clk_33m);
    chk_outputs_zero("reset");
    @(posedge clk_33m);
    #2 rst = 1'b0;

    // Basic 2x2 sprite.
    for (int n = 0; n < 4; n++) rom_mem[16'h100 + n] = 3'(n + 1);
    send_cmd(10, 20, 2, 2, 'h100, 4, k);
    done(k, 4);

    // Clipping at the right and bottom edges.
    for (int n = 0; n < 8; n++) rom_mem[16'h200 + n] = 3'd5;
    send_cmd(1278, 299, 4, 2, 'h200, 8, k);
    done(k, 8);

    // Empty sprites: no ROM access, no writes.
    send_cmd(50, 50, 0, 3, 'h700, 0, k);
    done(k, 0);
    chk("rom_addr_w0", 32'(rom_addr), 32'h207);
    send_cmd(50, 50, 3, 0, 'h700, 0, k);
    done(k, 0);
    chk("rom_addr_h0", 32'(rom_addr), 32'h207);

    // Transparent pixels.
    rom_mem[16'h300] = 3'd0;
    rom_mem[16'h301] = 3'd7;
    rom_mem[16'h302] = 3'd0;
    rom_mem[16'h303] = 3'd7;
    send_cmd(100, 50, 4, 1, 'h300, 4, k);
    done(k, 4);

    // Frame swap after 20 pixels of an 8x8 sprite.
    for (int n = 0; n < 64; n++) rom_mem[16'h400 + n] = 3'((n % 7) + 1);
    send_cmd(200, 100, 8, 8, 'h400, 17, k);
    at_neg(k + 19);
    chk("frame_start_pre", 32'(frame_start), 32'd0);
    rst_screen_33m = 1'b1;
    at_neg(k + 20);
    chk("frame_start_pulse", 32'(frame_start), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    for (int t = k + 21; t <= k + 24; t++) begin
      at_neg(t);
      chk("frame_start_once", 32'(frame_start), 32'd0);
      chk("ready_in_swap", 32'(cmd_bus.cmd_ready), 32'd0);
    end
    rst_screen_33m = 1'b0;
    #1 chk("ready_after_swap", 32'(cmd_bus.cmd_ready), 32'd1);

    // Asynchronous reset during DRAW, then a fresh command.
    for (int n = 0; n < 16; n++) rom_mem[16'h500 + n] = 3'((n % 6) + 1);
    send_cmd(30, 40, 4, 4, 'h500, 2, k);
    at_neg(k + 4);
    @(posedge clk_33m);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("async_rst");
    at_neg(k + 7);
    rst = 1'b0;
    rom_mem[16'h600] = 3'd6;
    rom_mem[16'h601] = 3'd1;
    rom_mem[16'h602] = 3'd2;
    send_cmd(5, 6, 3, 1, 'h600, 3, k);
    done(k, 3);

    repeat (4) @(negedge clk_33m);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    chk("addrs_left", 32'(addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
